key_search_scheduler: RTL and testbench

- Dispatches candidate RC4 secret keys to NUM_CORES parallel decrypt cores. Each core owns a private s/d/e memory set.
- Collects the done/found results and stops dispatching on the first success. Reports the winning key for the seven-segment display and the LED status outputs.
- Sits between the top-level board wrapper and the array of datapath cores.

---
 rtl/key_search_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_key_search_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_scheduler.sv
// key_search_scheduler: hands consecutive RC4 candidate keys to NUM_CORES
// decrypt cores and keeps each core's key stable while that core is busy.
// It stops issuing keys after the first success and reports the winning key.
// Optional build macro KEY_SEARCH_PROGRESS_EN adds a keys_tried output that
// counts finished attempts.
module key_search_scheduler #(
  parameter int                   NUM_CORES = 4,
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_found,
  output logic                           busy,
  output logic                           done,
  output logic                           key_found,
  output logic [KEY_WIDTH-1:0]           found_key
`ifdef KEY_SEARCH_PROGRESS_EN
  ,
  output logic [KEY_WIDTH:0]             keys_tried
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // One extra bit so the counter can step past an all-ones KEY_MAX without wrapping.
  localparam logic [KEY_WIDTH:0] KEY_LIMIT = {1'b0, KEY_MAX};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [NUM_CORES-1:0]           core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0]           core_start_q, core_start_d;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key_q, core_key_d;
  logic [KEY_WIDTH:0]             next_key_q, next_key_d;
  logic [KEY_WIDTH-1:0]           found_key_q, found_key_d;
  logic                           key_found_q, key_found_d;

  logic [NUM_CORES-1:0] accepted;
  logic [NUM_CORES-1:0] hit_vec;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic                 free_any;
  logic [IDX_W-1:0]     free_idx;
  logic                 keys_left;
  logic                 launch;
  logic                 take_found;
  logic                 clear;

  // Completion pulses only count for cores that are actually running an attempt.
  assign accepted  = core_done & core_busy_q;
  assign hit_vec   = accepted & core_found;
  assign keys_left = (next_key_q <= KEY_LIMIT);

  // Lowest-index priority pick of the free core and of the successful core.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    hit_any  = 1'b0;
    hit_idx  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!core_busy_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_DISPATCH;
      S_DISPATCH: if (hit_any || !keys_left) state_d = S_DRAIN;
      S_DRAIN:    if (core_busy_q == '0) state_d = S_DONE;
      S_DONE:     if (!start) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State-decoded controls: launch is suppressed on the cycle a success arrives.
  always_comb begin
    busy       = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    clear      = (state_q == S_IDLE) && start;
    launch     = (state_q == S_DISPATCH) && !hit_any && keys_left && free_any;
    take_found = hit_any && ((state_q == S_DISPATCH) ||
                             ((state_q == S_DRAIN) && !key_found_q));
  end

  // Datapath next-state: busy tracking, key hand-out and result capture.
  always_comb begin
    core_busy_d  = core_busy_q & ~accepted;
    core_start_d = '0;
    core_key_d   = core_key_q;
    next_key_d   = next_key_q;
    found_key_d  = found_key_q;
    key_found_d  = key_found_q;
    if (launch) begin
      core_busy_d[free_idx]                          = 1'b1;
      core_start_d[free_idx]                         = 1'b1;
      core_key_d[free_idx*KEY_WIDTH +: KEY_WIDTH]    = next_key_q[KEY_WIDTH-1:0];
      next_key_d                                     = next_key_q + 1'b1;
    end
    if (take_found) begin
      found_key_d = core_key_q[hit_idx*KEY_WIDTH +: KEY_WIDTH];
      key_found_d = 1'b1;
    end
    if (clear) begin
      core_busy_d = '0;
      next_key_d  = '0;
      found_key_d = '0;
      key_found_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_busy_q  <= '0;
      core_start_q <= '0;
      core_key_q   <= '0;
      next_key_q   <= '0;
      found_key_q  <= '0;
      key_found_q  <= 1'b0;
    end else begin
      core_busy_q  <= core_busy_d;
      core_start_q <= core_start_d;
      core_key_q   <= core_key_d;
      next_key_q   <= next_key_d;
      found_key_q  <= found_key_d;
      key_found_q  <= key_found_d;
    end
  end

`ifdef KEY_SEARCH_PROGRESS_EN
  logic [KEY_WIDTH:0] keys_tried_q, keys_tried_d;
  logic [KEY_WIDTH:0] tried_inc;

  // Progress count: add the number of accepted completions each active cycle.
  always_comb begin
    tried_inc = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      tried_inc = tried_inc + (KEY_WIDTH + 1)'(accepted[i]);
    end
    keys_tried_d = keys_tried_q;
    if (clear) begin
      keys_tried_d = '0;
    end else if (busy) begin
      keys_tried_d = keys_tried_q + tried_inc;
    end
  end

  // Progress counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keys_tried_q <= '0;
    end else begin
      keys_tried_q <= keys_tried_d;
    end
  end

  assign keys_tried = keys_tried_q;
`endif

  assign core_start = core_start_q;
  assign core_key   = core_key_q;
  assign key_found  = key_found_q;
  assign found_key  = found_key_q;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Bench for key_search_scheduler with two cores and a 4-bit key space whose
// KEY_MAX is all ones, so the top-of-range keys also cover the no-wrap case.
module tb_key_search_scheduler;

  localparam int              NC    = 2;
  localparam int              KW    = 4;
  localparam logic [KW-1:0]   KMAX  = 4'hF;
  localparam int              NKEYS = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [NC-1:0]     core_start;
  logic [NC*KW-1:0]  core_key;
  logic [NC-1:0]     core_done = '0;
  logic [NC-1:0]     core_found = '0;
  logic              busy, done, key_found;
  logic [KW-1:0]     found_key;
`ifdef KEY_SEARCH_PROGRESS_EN
  logic [KW:0]       keys_tried;
`endif

  key_search_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(KMAX)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .core_start(core_start), .core_key(core_key),
    .core_done(core_done), .core_found(core_found),
    .busy(busy), .done(done), .key_found(key_found), .found_key(found_key)
`ifdef KEY_SEARCH_PROGRESS_EN
    , .keys_tried(keys_tried)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void check(string name, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endfunction

  // Core model and launch scoreboard state.
  int            cnt [NC];
  logic [KW-1:0] rkey [NC];
  int            target = -1;
  int            lat = 5;
  bit            auto_en = 1'b1;
  logic [NC-1:0] man_done = '0;
  logic [NC-1:0] man_found = '0;
  int            launches = 0;
  int            late_starts = 0;
  logic [KW-1:0] sbq [$];

  // Monitors launches against the expected key order and models the cores.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NC; i++) cnt[i] = 0;
      core_done  = '0;
      core_found = '0;
    end else begin
      check("start_at_most_one", ($countones(core_start) <= 1) ? 1 : 0, 1);
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          logic [KW-1:0] k;
          k = core_key[i*KW +: KW];
          launches++;
          if (key_found) late_starts++;
          if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL extra_launch: core %0d got key %0d, expected no launch", i, k);
          end else begin
            check("launch_key", k, sbq.pop_front());
          end
        end
      end
      if (auto_en) begin
        core_done  = '0;
        core_found = '0;
        for (int i = 0; i < NC; i++) begin
          if (core_start[i]) begin
            cnt[i]  = lat;
            rkey[i] = core_key[i*KW +: KW];
          end else if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
              core_done[i]  = 1'b1;
              core_found[i] = (int'(rkey[i]) == target);
            end
          end
        end
      end else begin
        core_done  = man_done;
        core_found = man_found;
      end
    end
  end

  typedef struct {
    int tgt;
    int lat;
    int exp_kf;
    int exp_fk;
    int exp_launch;
    int exp_tried;
  } vec_t;

  vec_t tbl [5];

  task automatic begin_search(int tgt, int l, bit automode);
    target   = tgt;
    lat      = l;
    auto_en  = automode;
    man_done = '0;
    man_found = '0;
    launches = 0;
    late_starts = 0;
    sbq.delete();
    for (int k = 0; k < NKEYS; k++) sbq.push_back(KW'(k));
    @(negedge clk); #1;
    start = 1'b1;
  endtask

  task automatic wait_done(string tag);
    int c = 0;
    while (!done && c < 3000) begin
      @(negedge clk); #1;
      c++;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  task automatic finish_search(vec_t v, string tag);
    int outstanding;
    wait_done(tag);
    outstanding = 0;
    for (int i = 0; i < NC; i++) if (cnt[i] > 0) outstanding++;
    check({tag, "_cores_idle_at_done"}, outstanding, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_key_found"}, key_found, v.exp_kf);
    check({tag, "_found_key"}, found_key, v.exp_fk);
    check({tag, "_launches"}, launches, v.exp_launch);
    check({tag, "_starts_after_found"}, late_starts, 0);
`ifdef KEY_SEARCH_PROGRESS_EN
    check({tag, "_keys_tried"}, keys_tried, v.exp_tried);
`endif
  endtask

  task automatic to_idle(string tag);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_idle_done"}, done, 0);
  endtask

  task automatic wait_launches(int n, string tag);
    int c = 0;
    while (launches < n && c < 200) begin
      @(negedge clk); #1;
      c++;
    end
    check({tag, "_launch_count"}, launches, n);
  endtask

  initial begin
    vec_t v;
    //      tgt lat kf fk launch tried
    tbl[0] = '{-1, 5, 0, 0, 16, 16};
    tbl[1] = '{ 9, 5, 1, 9, 10, 10};
    tbl[2] = '{ 8, 5, 1, 8, 10, 10};
    tbl[3] = '{ 0, 3, 1, 0,  2,  2};
    tbl[4] = '{15, 2, 1, 15, 16, 16};

    // Reset state
    #12;
    check("rst_core_start", core_start, 0);
    check("rst_core_key", core_key, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_key_found", key_found, 0);
    check("rst_found_key", found_key, 0);
`ifdef KEY_SEARCH_PROGRESS_EN
    check("rst_keys_tried", keys_tried, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven searches
    for (int r = 0; r < 5; r++) begin
      begin_search(tbl[r].tgt, tbl[r].lat, 1'b1);
      finish_search(tbl[r], $sformatf("row%0d", r));
      to_idle($sformatf("row%0d", r));
    end

    // Simultaneous success on both cores: lowest index wins; first-launch latency
    begin_search(-1, 5, 1'b0);
    @(negedge clk); #1;
    check("sim_no_launch_yet", launches, 0);
    @(negedge clk); #1;
    check("sim_first_launch", launches, 1);
    check("sim_first_core", core_start, 1);
    check("sim_first_key", core_key[0 +: KW], 0);
    wait_launches(2, "sim_a");
    man_done = 2'b11;
    @(negedge clk); #1;
    man_done = 2'b00;
    wait_launches(4, "sim_b");
    man_done = 2'b11;
    @(negedge clk); #1;
    man_done = 2'b00;
    wait_launches(6, "sim_c");
    check("sim_key_core0", core_key[0 +: KW], 4);
    check("sim_key_core1", core_key[KW +: KW], 5);
    man_done  = 2'b11;
    man_found = 2'b11;
    @(negedge clk); #1;
    man_done  = 2'b00;
    man_found = 2'b00;
    v = '{-1, 5, 1, 4, 6, 6};
    finish_search(v, "sim");
    to_idle("sim");

    // Reset mid-search after key 6 is issued, then a fresh search from key 0
    begin_search(-1, 5, 1'b1);
    wait_launches(7, "rst_mid");
    #2;
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check("rstmid_core_start", core_start, 0);
    check("rstmid_core_key", core_key, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_key_found", key_found, 0);
    check("rstmid_found_key", found_key, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    begin_search(-1, 5, 1'b1);
    finish_search(tbl[0], "after_rst");
    to_idle("after_rst");

    // start held through DONE: no restart; drop and raise clears the flags
    begin_search(8, 5, 1'b1);
    finish_search(tbl[2], "hold");
    repeat (5) @(negedge clk);
    #1;
    check("hold_done", done, 1);
    check("hold_launches", launches, 10);
    check("hold_key_found", key_found, 1);
    check("hold_found_key", found_key, 8);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_key_found_kept", key_found, 1);
    begin_search(-1, 5, 1'b1);
    @(negedge clk); #1;
    check("restart_key_found", key_found, 0);
    check("restart_found_key", found_key, 0);
    check("restart_busy", busy, 1);
    finish_search(tbl[0], "restart");
    to_idle("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
